// File: rtl/display_ram_pkg.sv
// rtl/display_ram_pkg.sv - shared constants, state encoding and width helper for display_ram_engine
// Contents:
//   OP_CLEAR / OP_SCROLL  engine opcodes carried on cmd_op
//   state_e               engine state machine encoding
//   idx_width()           bits needed to index COLS*ROWS screen cells
package display_ram_pkg;

    localparam logic OP_CLEAR  = 1'b0;
    localparam logic OP_SCROLL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_SCR_RD   = 3'd2,
        ST_SCR_WR   = 3'd3,
        ST_SCR_FILL = 3'd4
    } state_e;

    // Never returns 0 so a one-cell screen still gets a legal vector width.
    function automatic int idx_width(input int cols, input int rows);
        int n;
        n = cols * rows;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dp_ram.sv
// rtl/dp_ram.sv - true dual-port read-first RAM with registered outputs
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset (output registers only)
//   a_en_i, a_we_i, a_addr_i,
//   a_wdata_i, a_q_o                 port A; a_q_o updates only on enabled cycles
//   b_we_i, b_addr_i, b_wdata_i,
//   b_q_o                            port B; reads every cycle
module dp_ram #(
    parameter int A_WIDTH = 11,
    parameter int D_WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               a_en_i,
    input  logic               a_we_i,
    input  logic [A_WIDTH-1:0] a_addr_i,
    input  logic [D_WIDTH-1:0] a_wdata_i,
    output logic [D_WIDTH-1:0] a_q_o,
    input  logic               b_we_i,
    input  logic [A_WIDTH-1:0] b_addr_i,
    input  logic [D_WIDTH-1:0] b_wdata_i,
    output logic [D_WIDTH-1:0] b_q_o
);

    logic [D_WIDTH-1:0] mem_q [2**A_WIDTH];
    logic [D_WIDTH-1:0] a_rdata_q;
    logic [D_WIDTH-1:0] b_rdata_q;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (a_en_i && a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_wdata_i;
        end
    end

    // Reads sample the array before this edge's writes land: read-first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_en_i) begin
                a_rdata_q <= mem_q[a_addr_i];
            end
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_q_o = a_rdata_q;
    assign b_q_o = b_rdata_q;

endmodule

// File: rtl/display_ram_engine.sv
// rtl/display_ram_engine.sv - character RAM with CPU port, video port and clear/scroll engine
// Ports:
//   clock, reset                              single clock, synchronous active-high reset
//   cpu_req, cpu_wren, cpu_addr, cpu_wdata     CPU request (level, held until cpu_ack)
//   cpu_ack, cpu_q                            one-cycle completion pulse and read data
//   vid_addr, vid_q                           video read port, fixed one-cycle latency
//   cmd_valid, cmd_op, cmd_ready              engine command handshake (0 CLEAR, 1 SCROLL)
//   busy, done                                engine owns port A / command completed pulse
module display_ram_engine
    import display_ram_pkg::*;
#(
    parameter int                 A_WIDTH    = 11,
    parameter int                 D_WIDTH    = 8,
    parameter int                 COLS       = 80,
    parameter int                 ROWS       = 25,
    parameter logic [D_WIDTH-1:0] FILL_VALUE = 'h20
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_wren,
    input  logic [A_WIDTH-1:0] cpu_addr,
    input  logic [D_WIDTH-1:0] cpu_wdata,
    output logic               cpu_ack,
    output logic [D_WIDTH-1:0] cpu_q,
    input  logic [A_WIDTH-1:0] vid_addr,
    output logic [D_WIDTH-1:0] vid_q,
    input  logic               cmd_valid,
    input  logic               cmd_op,
    output logic               cmd_ready,
    output logic               busy,
    output logic               done
);

    localparam int N_CELLS = COLS * ROWS;
    localparam int IW      = idx_width(COLS, ROWS);

    localparam logic [IW-1:0] LAST_IDX     = IW'(N_CELLS - 1);
    localparam logic [IW-1:0] SCR_LAST_IDX = IW'(COLS * (ROWS - 1) - 1);

    if (COLS < 1 || ROWS < 1 || COLS * ROWS > 2**A_WIDTH) begin : g_bad_geometry
        $error("display_ram_engine: COLS*ROWS does not fit in 2**A_WIDTH cells");
    end

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               done_q, done_d;
    logic               cpu_ack_q;
    logic [D_WIDTH-1:0] cpu_hold_q;

    logic               accept;
    logic               cpu_go;
    logic               ram_en;
    logic               ram_we;
    logic [A_WIDTH-1:0] ram_addr;
    logic [D_WIDTH-1:0] ram_wdata;
    logic [D_WIDTH-1:0] ram_a_q;

    // A pending command beats a CPU request in the same idle cycle.
    assign accept = cmd_valid && (state_q == ST_IDLE);
    assign cpu_go = cpu_req && !cmd_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                ram_en    = cpu_go;
                ram_we    = cpu_wren;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                if (accept) begin
                    idx_d = '0;
                    if (cmd_op == OP_CLEAR) begin
                        state_d = ST_CLEAR;
                    end else if (ROWS == 1) begin
                        state_d = ST_SCR_FILL;
                    end else begin
                        state_d = ST_SCR_RD;
                    end
                end
            end
            ST_CLEAR, ST_SCR_FILL: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = A_WIDTH'(idx_q);
                ram_wdata = FILL_VALUE;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_SCR_RD: begin
                ram_en   = 1'b1;
                ram_addr = A_WIDTH'(idx_q) + A_WIDTH'(COLS);
                state_d  = ST_SCR_WR;
            end
            ST_SCR_WR: begin
                // Port A's output register doubles as the scroll holding register.
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = A_WIDTH'(idx_q);
                ram_wdata = ram_a_q;
                idx_d     = idx_q + IW'(1);
                state_d   = (idx_q == SCR_LAST_IDX) ? ST_SCR_FILL : ST_SCR_RD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // No memory writes while reset is held, whatever the inputs do.
        if (reset) begin
            ram_en = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            done_q     <= 1'b0;
            cpu_ack_q  <= 1'b0;
            cpu_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            cpu_ack_q <= cpu_go;
            // Freeze the CPU result so later engine reads cannot disturb cpu_q.
            if (cpu_ack_q) begin
                cpu_hold_q <= ram_a_q;
            end
        end
    end

    dp_ram #(
        .A_WIDTH (A_WIDTH),
        .D_WIDTH (D_WIDTH)
    ) u_ram (
        .clk_i     (clock),
        .rst_i     (reset),
        .a_en_i    (ram_en),
        .a_we_i    (ram_we),
        .a_addr_i  (ram_addr),
        .a_wdata_i (ram_wdata),
        .a_q_o     (ram_a_q),
        .b_we_i    (1'b0),
        .b_addr_i  (vid_addr),
        .b_wdata_i ('0),
        .b_q_o     (vid_q)
    );

    assign busy      = (state_q != ST_IDLE);
    assign cmd_ready = !busy;
    assign done      = done_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_q     = cpu_ack_q ? ram_a_q : cpu_hold_q;

endmodule

// File: tb/tb_display_ram_engine.sv
// tb/tb_display_ram_engine.sv - scoreboard bench for display_ram_engine with a screen-level model
module tb_display_ram_engine;

    localparam int         AW    = 5;
    localparam int         DW    = 8;
    localparam int         COLS  = 4;
    localparam int         ROWS  = 3;
    localparam int         N     = COLS * ROWS;
    localparam int         DEPTH = 2**AW;
    localparam logic [7:0] FILL  = 8'h20;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req;
    logic          cpu_wren;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_q;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_q;
    logic          cmd_valid;
    logic          cmd_op;
    logic          cmd_ready;
    logic          busy;
    logic          done;

    display_ram_engine #(
        .A_WIDTH    (AW),
        .D_WIDTH    (DW),
        .COLS       (COLS),
        .ROWS       (ROWS),
        .FILL_VALUE (FILL)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_wren  (cpu_wren),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_q     (cpu_q),
        .vid_addr  (vid_addr),
        .vid_q     (vid_q),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Screen model: commands are applied atomically when issued.
    logic [7:0] model_mem [DEPTH];
    logic [7:0] cpu_exp_q [$];
    bit         cpu_care_q [$];
    logic [7:0] vid_exp_q [$];
    logic [7:0] mon_exp;
    bit         mon_care;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per cpu_ack and per pending video read.
    always @(posedge clock) begin
        #1;
        if (cpu_ack) begin
            if (cpu_exp_q.size() == 0) begin
                check("cpu_ack_unexpected", {31'd0, cpu_ack}, 32'd0);
            end else begin
                mon_exp  = cpu_exp_q.pop_front();
                mon_care = cpu_care_q.pop_front();
                if (mon_care) check("cpu_q", {24'd0, cpu_q}, {24'd0, mon_exp});
            end
        end
        if (vid_exp_q.size() > 0) begin
            mon_exp = vid_exp_q.pop_front();
            check("vid_q", {24'd0, vid_q}, {24'd0, mon_exp});
        end
    end

    task automatic model_cmd(input logic op);
        if (op == 1'b0) begin
            for (int i = 0; i < N; i++) model_mem[i] = FILL;
        end else begin
            for (int i = 0; i < N - COLS; i++) model_mem[i] = model_mem[i + COLS];
            for (int i = N - COLS; i < N; i++) model_mem[i] = FILL;
        end
    endtask

    // exp_lat: rising edges from request to visible ack; 0 skips the latency check.
    task automatic cpu_op(input logic wr, input logic [AW-1:0] a, input logic [7:0] d,
                          input bit care, input int exp_lat);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        @(negedge clock);
        cpu_req   = 1'b1;
        cpu_wren  = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_exp_q.push_back(model_mem[a]);
        cpu_care_q.push_back(care);
        if (wr) model_mem[a] = d;
        while (!got && lat < 200) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (cpu_ack) got = 1'b1;
        end
        cpu_req = 1'b0;
        check("cpu_ack_seen", {31'd0, got}, 32'd1);
        if (exp_lat > 0) check("cpu_ack_latency", lat, exp_lat);
    endtask

    task automatic vid_read(input logic [AW-1:0] a);
        @(negedge clock);
        vid_addr = a;
        vid_exp_q.push_back(model_mem[a]);
    endtask

    task automatic vid_dump();
        for (int i = 0; i < DEPTH; i++) vid_read(AW'(i));
        @(negedge clock);
    endtask

    task automatic run_cmd(input logic op, input int exp_busy);
        int n;
        bit early_done;
        n = 0;
        early_done = 1'b0;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("cmd_ready_while_busy", {31'd0, cmd_ready}, 32'd0);
        while (busy && n < 500) begin
            n++;
            if (done) early_done = 1'b1;
            @(negedge clock);
        end
        check("busy_cycles", n, exp_busy);
        check("done_while_busy", {31'd0, early_done}, 32'd0);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("cmd_ready_at_done", {31'd0, cmd_ready}, 32'd1);
        @(negedge clock);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_wren  = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        vid_addr  = '0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        check("rst_cpu_q", {24'd0, cpu_q}, 32'd0);
        check("rst_vid_q", {24'd0, vid_q}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        // Give every cell a known value; old contents are unknown.
        for (int i = 0; i < DEPTH; i++) cpu_op(1'b1, AW'(i), 8'($urandom), 1'b0, 1);

        // CPU round trip.
        cpu_op(1'b1, 5'd5, 8'h41, 1'b1, 1);
        cpu_op(1'b0, 5'd5, 8'h00, 1'b1, 1);

        // Read-first: video and CPU write to the same address on the same edge.
        @(negedge clock);
        vid_addr = 5'd5;
        vid_exp_q.push_back(model_mem[5]);
        cpu_req   = 1'b1;
        cpu_wren  = 1'b1;
        cpu_addr  = 5'd5;
        cpu_wdata = 8'h42;
        cpu_exp_q.push_back(model_mem[5]);
        cpu_care_q.push_back(1'b1);
        model_mem[5] = 8'h42;
        @(posedge clock);
        @(negedge clock);
        cpu_req = 1'b0;
        check("rf_cpu_ack", {31'd0, cpu_ack}, 32'd1);
        vid_exp_q.push_back(model_mem[5]);
        @(negedge clock);
        vid_dump();

        // CLEAR timing and content, with a CPU write stalled behind it.
        model_cmd(1'b0);
        fork
            run_cmd(1'b0, N);
            cpu_op(1'b1, 5'd3, 8'h99, 1'b1, N + 2);
        join
        vid_dump();

        // SCROLL with a preloaded screen and a CPU read held through it.
        for (int i = 0; i < N; i++) cpu_op(1'b1, AW'(i), 8'(i), 1'b1, 1);
        model_cmd(1'b1);
        fork
            run_cmd(1'b1, 2 * COLS * (ROWS - 1) + COLS);
            cpu_op(1'b0, 5'd7, 8'h00, 1'b1, 2 * COLS * (ROWS - 1) + COLS + 2);
        join
        vid_dump();

        // Reset part-way through a SCROLL.
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        cpu_op(1'b0, 5'd20, 8'h00, 1'b1, 1);
        model_cmd(1'b0);
        run_cmd(1'b0, N);
        vid_dump();

        // Randomised traffic against the model.
        for (int k = 0; k < 60; k++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5) begin
                cpu_op(1'(r & 1), AW'($urandom_range(0, DEPTH - 1)), 8'($urandom), 1'b1, 1);
            end else if (r <= 7) begin
                vid_read(AW'($urandom_range(0, DEPTH - 1)));
                @(negedge clock);
            end else begin
                model_cmd(1'(r - 8));
                run_cmd(1'(r - 8), (r == 8) ? N : 2 * COLS * (ROWS - 1) + COLS);
            end
        end
        vid_dump();

        repeat (3) @(negedge clock);
        check("cpu_queue_drained", cpu_exp_q.size(), 0);
        check("vid_queue_drained", vid_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
